// File: rtl/hex_entry_pkg.sv
// Shared constants for the hex word editor: button indices, default
// timing parameters and the width of the millisecond counters.
package hex_entry_pkg;

  localparam int unsigned NUM_BTN = 5;

  localparam int unsigned UP = 0;
  localparam int unsigned DN = 1;
  localparam int unsigned LT = 2;
  localparam int unsigned RT = 3;
  localparam int unsigned OK = 4;

  localparam int unsigned DEB_MS_DEF     = 20;
  localparam int unsigned REP_DLY_MS_DEF = 500;
  localparam int unsigned REP_PER_MS_DEF = 100;

  // 10 bits covers up to 1023 ms
  localparam int unsigned CNT_W = 10;

endpackage

// File: rtl/hex_entry_btn.sv
// One push button: 2-FF synchronizer, ce1ms-based debouncer, rising-edge
// event and optional hold-to-repeat event generation.
module btn_debounce
  import hex_entry_pkg::*;
#(
  parameter int unsigned DEB_MS     = DEB_MS_DEF,
  parameter int unsigned REP_DLY_MS = REP_DLY_MS_DEF,
  parameter int unsigned REP_PER_MS = REP_PER_MS_DEF,
  parameter bit          REPEAT     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic ce1ms,
  input  logic btn,
  output logic lvl,
  output logic ev
);

  localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEB_MS);
  localparam logic [CNT_W-1:0] DLY_LIM = CNT_W'(REP_DLY_MS);
  // Reloading to DLY-PER makes later repeats land every PER ms.
  localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(REP_DLY_MS - REP_PER_MS);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             lvl_q, lvl_d;
  logic             ev_q, ev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    lvl_d   = lvl_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    ev_d    = 1'b0;

    if (ce1ms) begin
      if (sync2_q != lvl_q) begin
        if (cnt_q + 1'b1 == DEB_LIM) begin
          lvl_d = ~lvl_q;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end

      if (REPEAT && lvl_q) begin
        if (hold_q + 1'b1 == DLY_LIM) begin
          ev_d   = 1'b1;
          hold_d = RELOAD;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
    end

    if (!lvl_q) begin
      hold_d = '0;
    end

    if (lvl_d && !lvl_q) begin
      ev_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      ev_q    <= 1'b0;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      lvl_q   <= lvl_d;
      ev_q    <= ev_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  assign lvl = lvl_q;
  assign ev  = ev_q;

endmodule

// File: rtl/hex_entry.sv
// Button-driven 16-bit hex word editor: five debounced buttons edit one
// nibble at a time under a cursor; ok commits the word with a strobe.
module hex_entry
  import hex_entry_pkg::*;
#(
  parameter int unsigned DEB_MS     = DEB_MS_DEF,
  parameter int unsigned REP_DLY_MS = REP_DLY_MS_DEF,
  parameter int unsigned REP_PER_MS = REP_PER_MS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce1ms,
  input  logic        btn_up,
  input  logic        btn_dn,
  input  logic        btn_lt,
  input  logic        btn_rt,
  input  logic        btn_ok,
  output logic [15:0] dat,
  output logic [1:0]  ptr,
  output logic [15:0] word,
  output logic        stb
);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_lvl_unused;
  logic [NUM_BTN-1:0] ev;

  assign btn_raw = {btn_ok, btn_rt, btn_lt, btn_dn, btn_up};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEB_MS     (DEB_MS),
      .REP_DLY_MS (REP_DLY_MS),
      .REP_PER_MS (REP_PER_MS),
      .REPEAT     ((i == UP) || (i == DN))
    ) u_btn (
      .clk   (clk),
      .rst   (rst),
      .ce1ms (ce1ms),
      .btn   (btn_raw[i]),
      .lvl   (btn_lvl_unused[i]),
      .ev    (ev[i])
    );
  end

  logic [15:0] dat_q, dat_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [15:0] word_q, word_d;
  logic        stb_q, stb_d;
  logic [3:0]  nib;

  always_comb begin
    dat_d  = dat_q;
    ptr_d  = ptr_q;
    word_d = word_q;
    stb_d  = 1'b0;
    nib    = dat_q[{ptr_q, 2'b00} +: 4];

    // Commit takes priority and drops every other event in the same cycle.
    if (ev[OK]) begin
      word_d = dat_q;
      stb_d  = 1'b1;
    end else begin
      if (ev[UP] ^ ev[DN]) begin
        dat_d[{ptr_q, 2'b00} +: 4] = ev[UP] ? nib + 4'd1 : nib - 4'd1;
      end
      if (ev[LT] ^ ev[RT]) begin
        ptr_d = ev[LT] ? ptr_q + 2'd1 : ptr_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat_q  <= '0;
      ptr_q  <= '0;
      word_q <= '0;
      stb_q  <= 1'b0;
    end else begin
      dat_q  <= dat_d;
      ptr_q  <= ptr_d;
      word_q <= word_d;
      stb_q  <= stb_d;
    end
  end

  assign dat  = dat_q;
  assign ptr  = ptr_q;
  assign word = word_q;
  assign stb  = stb_q;

endmodule

// File: tb/tb_hex_entry.sv
// Directed bench for hex_entry; ce1ms is compressed to one strobe every
// CE_DIV clocks so that multi-second holds stay short in simulation.
module tb_hex_entry;
  import hex_entry_pkg::*;

  localparam int unsigned CE_DIV = 4;
  localparam logic [4:0] M_UP = 5'b00001;
  localparam logic [4:0] M_DN = 5'b00010;
  localparam logic [4:0] M_LT = 5'b00100;
  localparam logic [4:0] M_RT = 5'b01000;
  localparam logic [4:0] M_OK = 5'b10000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce1ms = 1'b0;
  logic        ce_en = 1'b1;
  logic [4:0]  btn_v = '0;
  logic [15:0] dat, word;
  logic [1:0]  ptr;
  logic        stb;

  int n_cmp = 0;
  int n_err = 0;
  int stb_cnt = 0;
  int exp_stb = 0;

  hex_entry #(
    .DEB_MS     (20),
    .REP_DLY_MS (500),
    .REP_PER_MS (100)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ce1ms  (ce1ms),
    .btn_up (btn_v[UP]),
    .btn_dn (btn_v[DN]),
    .btn_lt (btn_v[LT]),
    .btn_rt (btn_v[RT]),
    .btn_ok (btn_v[OK]),
    .dat    (dat),
    .ptr    (ptr),
    .word   (word),
    .stb    (stb)
  );

  always #5 clk = ~clk;

  initial begin
    int unsigned div;
    div = 0;
    forever begin
      @(negedge clk);
      ce1ms = ce_en && (div == CE_DIV - 1);
      div   = (div == CE_DIV - 1) ? 0 : div + 1;
    end
  end

  // Counts clocks with stb high, so a stretched strobe also shows up.
  always @(negedge clk) if (stb === 1'b1) stb_cnt++;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic wait_ms(input int unsigned ms);
    repeat (ms * CE_DIV) @(negedge clk);
  endtask

  task automatic tap(input logic [4:0] m, input int unsigned hold_ms);
    @(negedge clk);
    btn_v = m;
    wait_ms(hold_ms);
    btn_v = '0;
    wait_ms(30);
  endtask

  task automatic tap_n(input logic [4:0] m, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) tap(m, 25);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    logic [4:0]  btn;
    logic [15:0] dat;
    logic [1:0]  ptr;
    logic [15:0] word;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int lat;
    int nchg;
    int tchg[8];
    logic [15:0] prev;

    vecs[0]  = '{M_DN,               16'h000F, 2'd0, 16'h0000};
    vecs[1]  = '{M_UP,               16'h0000, 2'd0, 16'h0000};
    vecs[2]  = '{M_DN,               16'h000F, 2'd0, 16'h0000};
    vecs[3]  = '{M_LT,               16'h000F, 2'd1, 16'h0000};
    vecs[4]  = '{M_LT,               16'h000F, 2'd2, 16'h0000};
    vecs[5]  = '{M_DN,               16'h0F0F, 2'd2, 16'h0000};
    vecs[6]  = '{M_RT,               16'h0F0F, 2'd1, 16'h0000};
    vecs[7]  = '{M_RT,               16'h0F0F, 2'd0, 16'h0000};
    vecs[8]  = '{M_RT,               16'h0F0F, 2'd3, 16'h0000};
    vecs[9]  = '{M_LT,               16'h0F0F, 2'd0, 16'h0000};
    vecs[10] = '{M_UP | M_DN,        16'h0F0F, 2'd0, 16'h0000};
    vecs[11] = '{M_LT | M_RT,        16'h0F0F, 2'd0, 16'h0000};
    vecs[12] = '{M_UP | M_LT,        16'h0F00, 2'd1, 16'h0000};
    vecs[13] = '{M_DN | M_RT,        16'h0FF0, 2'd0, 16'h0000};
    vecs[14] = '{M_OK,               16'h0FF0, 2'd0, 16'h0FF0};
    vecs[15] = '{M_UP,               16'h0FF1, 2'd0, 16'h0FF0};
    vecs[16] = '{M_OK | M_UP | M_LT, 16'h0FF1, 2'd0, 16'h0FF1};

    // Reset values
    repeat (3) @(negedge clk);
    check("reset_dat", dat, 16'h0000);
    check("reset_ptr", {14'd0, ptr}, 16'd0);
    check("reset_word", word, 16'h0000);
    check("reset_stb", {15'd0, stb}, 16'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Tap up, then async reset in the middle of a hold
    @(negedge clk);
    btn_v = M_UP;
    wait_ms(25);
    check("tap_up_dat", dat, 16'h0001);
    check("tap_up_ptr", {14'd0, ptr}, 16'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_dat", dat, 16'h0000);
    check("async_rst_stb", {15'd0, stb}, 16'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_ms(25);
    check("held_after_rst_dat", dat, 16'h0001);
    btn_v = '0;
    wait_ms(30);
    do_reset();

    // Bounce: 5 ms of 1 ms period chatter then a 3 ms pulse
    for (int k = 0; k < 5; k++) begin
      btn_v = M_UP;
      repeat (CE_DIV / 2) @(negedge clk);
      btn_v = '0;
      repeat (CE_DIV / 2) @(negedge clk);
    end
    btn_v = M_UP;
    wait_ms(3);
    btn_v = '0;
    wait_ms(30);
    check("bounce_dat", dat, 16'h0000);

    // ce1ms stuck low: nothing is accepted
    ce_en = 1'b0;
    @(negedge clk);
    btn_v = M_UP | M_OK;
    wait_ms(60);
    btn_v = '0;
    repeat (8) @(negedge clk);
    check("ce_stuck_dat", dat, 16'h0000);
    check("ce_stuck_stb", 16'(stb_cnt), 16'd0);
    ce_en = 1'b1;
    wait_ms(30);
    check("ce_resume_dat", dat, 16'h0000);

    // Latency: 2 sync clocks + 20 ticks + ev cycle + register, phase 0..3
    @(negedge clk);
    btn_v = M_UP;
    lat = 0;
    while (dat == 16'h0000 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat < 80 || lat > 83) begin
      n_err++;
      $display("FAIL press_latency: got %0d clocks, expected 80..83", lat);
    end
    btn_v = '0;
    wait_ms(30);
    check("latency_dat", dat, 16'h0001);

    // Table of single and simultaneous taps
    do_reset();
    exp_stb = stb_cnt;
    for (int i = 0; i < 17; i++) begin
      tap(vecs[i].btn, 25);
      if (vecs[i].btn[OK]) exp_stb++;
      check($sformatf("vec%0d_dat", i), dat, vecs[i].dat);
      check($sformatf("vec%0d_ptr", i), {14'd0, ptr}, {14'd0, vecs[i].ptr});
      check($sformatf("vec%0d_word", i), word, vecs[i].word);
      check($sformatf("vec%0d_stb", i), 16'(stb_cnt), 16'(exp_stb));
    end

    // Auto-repeat: hold up 1020 ms, one press plus repeats at 500..1000 ms
    do_reset();
    nchg = 0;
    prev = dat;
    @(negedge clk);
    btn_v = M_UP;
    for (int c = 0; c < 4480; c++) begin
      @(negedge clk);
      if (c == 1020 * CE_DIV - 1) btn_v = '0;
      if (dat != prev) begin
        if (nchg < 8) tchg[nchg] = c;
        nchg++;
        prev = dat;
      end
    end
    check("hold_changes", 16'(nchg), 16'd7);
    check("hold_dat", dat, 16'h0007);
    if (nchg >= 7) begin
      check("hold_first_rep", 16'(tchg[1] - tchg[0]), 16'(500 * CE_DIV));
      for (int k = 1; k < 6; k++)
        check($sformatf("hold_rep%0d", k), 16'(tchg[k+1] - tchg[k]), 16'(100 * CE_DIV));
    end

    // Build 0xA5C3, then ok+up in one cycle, then hold ok for 2 s
    do_reset();
    tap_n(M_UP, 3);
    tap(M_LT, 25);
    tap_n(M_DN, 4);
    tap(M_LT, 25);
    tap_n(M_UP, 5);
    tap(M_LT, 25);
    tap_n(M_DN, 6);
    tap(M_LT, 25);
    check("build_dat", dat, 16'hA5C3);
    check("build_ptr", {14'd0, ptr}, 16'd0);
    exp_stb = stb_cnt + 1;
    tap(M_OK | M_UP, 25);
    check("ok_up_word", word, 16'hA5C3);
    check("ok_up_dat", dat, 16'hA5C3);
    check("ok_up_stb", 16'(stb_cnt), 16'(exp_stb));
    exp_stb = exp_stb + 1;
    @(negedge clk);
    btn_v = M_OK;
    wait_ms(2000);
    btn_v = '0;
    wait_ms(30);
    check("ok_hold_stb", 16'(stb_cnt), 16'(exp_stb));
    check("ok_hold_word", word, 16'hA5C3);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
